topk_dedup: RTL

- Parametrised successor to the glove's top-3 duplicate-gesture filter.
- Receives the TOP_K classifier indices of each frame and compares them against a ring of the last HIST_DEPTH recorded frames.
- Emits a one-cycle verdict: o_next=1 means a new gesture (forward to the decoder); o_next=0 means a duplicate (suppress).
- Sits between the classifier top-K sorter and the character/command decoder.

---
 rtl/topk_dedup_if.sv | 30 +++
 rtl/topk_dedup.sv | 134 +++++++++++++
 2 files changed

// File: rtl/topk_dedup_if.sv
// topk_dedup_if: frame/verdict bundle between the top-K sorter, the dedup
//   filter and the decoder.
// Frame side: i_valid, o_ready, i_tops (TOP_K packed indices), i_thresh, i_clear.
// Verdict side: o_valid (one-cycle strobe), o_next, o_overlap.
interface topk_dedup_if #(
  parameter int IDX_W = 5,
  parameter int TOP_K = 3
);
  localparam int OV_W = $clog2(TOP_K + 1);

  logic                     i_valid;
  logic                     o_ready;
  logic [TOP_K*IDX_W-1:0]   i_tops;
  logic [OV_W-1:0]          i_thresh;
  logic                     i_clear;
  logic                     o_valid;
  logic                     o_next;
  logic [OV_W-1:0]          o_overlap;

  // master drives frames and observes verdicts; slave is the filter.
  modport master (
    output i_valid, i_tops, i_thresh, i_clear,
    input  o_ready, o_valid, o_next, o_overlap
  );

  modport slave (
    input  i_valid, i_tops, i_thresh, i_clear,
    output o_ready, o_valid, o_next, o_overlap
  );
endinterface

// File: rtl/topk_dedup.sv
// topk_dedup: suppresses frames whose top-K class set overlaps any of the last
//   HIST_DEPTH recorded frames by at least i_thresh classes.
// Ports: i_clk, i_rst_n (async, active-low), bus (topk_dedup_if.slave):
//   frame in (i_valid/o_ready/i_tops/i_thresh/i_clear), verdict out
//   (o_valid/o_next/o_overlap); o_drop_cnt only with DEDUP_DROP_CNT_EN.
// Latency: verdict HIST_DEPTH+2 cycles after accept; o_ready is high only when idle.
// Optional macro DEDUP_DROP_CNT_EN adds a saturating 16-bit suppressed-frame counter.
module topk_dedup #(
  parameter int NUM_CLASSES = 32,
  parameter int IDX_W       = 5,
  parameter int TOP_K       = 3,
  parameter int HIST_DEPTH  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  topk_dedup_if.slave   bus
`ifdef DEDUP_DROP_CNT_EN
  ,
  output logic [15:0]   o_drop_cnt
`endif
);

  localparam int OV_W = $clog2(TOP_K + 1);
  localparam int J_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [J_W-1:0] J_LAST = J_W'(HIST_DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUILD = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]               state;
  logic [TOP_K*IDX_W-1:0]   tops_q;
  logic [OV_W-1:0]          thresh_q;
  logic [NUM_CLASSES-1:0]   cur_vec;
  logic [NUM_CLASSES-1:0]   build_vec;
  logic [NUM_CLASSES-1:0]   hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]    hist_vld;
  logic [J_W-1:0]           j;
  logic [OV_W-1:0]          max_ov;
  logic [OV_W-1:0]          ov_j;
  logic                     next_raw;

  // Only bits set in cur_vec can match, so the count never exceeds TOP_K
  // and OV_W bits cannot wrap.
  function automatic logic [OV_W-1:0] popcnt(input logic [NUM_CLASSES-1:0] v);
    logic [OV_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CLASSES; i++) c = c + OV_W'(v[i]);
    return c;
  endfunction

  // Membership vector: repeated indices land on the same bit, out-of-range
  // indices are dropped.
  always_comb begin
    build_vec = '0;
    for (int k = 0; k < TOP_K; k++) begin
      if (int'(tops_q[k*IDX_W +: IDX_W]) < NUM_CLASSES)
        build_vec[tops_q[k*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  always_comb begin
    ov_j = '0;
    if (hist_vld[j]) ov_j = popcnt(cur_vec & hist[j]);
  end

  // Threshold 0 disables suppression; thresholds above TOP_K can never be met.
  assign next_raw = (thresh_q == '0) || (max_ov < thresh_q);

  assign bus.o_ready   = (state == S_IDLE);
  assign bus.o_valid   = (state == S_OUT);
  assign bus.o_next    = (state == S_OUT) && next_raw;
  assign bus.o_overlap = (state == S_OUT) ? max_ov : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      tops_q   <= '0;
      thresh_q <= '0;
      cur_vec  <= '0;
      hist_vld <= '0;
      j        <= '0;
      max_ov   <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
`ifdef DEDUP_DROP_CNT_EN
      o_drop_cnt <= '0;
`endif
    end else if (bus.i_clear) begin
      // Flush wins over everything, including a coincident accept; the stale
      // vectors stay but are masked by the cleared valid bits.
      state    <= S_IDLE;
      hist_vld <= '0;
`ifdef DEDUP_DROP_CNT_EN
      o_drop_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            tops_q   <= bus.i_tops;
            thresh_q <= bus.i_thresh;
            state    <= S_BUILD;
          end
        end
        S_BUILD: begin
          cur_vec <= build_vec;
          max_ov  <= '0;
          j       <= '0;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (ov_j > max_ov) max_ov <= ov_j;
          if (j == J_LAST) state <= S_OUT;
          else             j     <= j + 1'b1;
        end
        default: begin
          // S_OUT: record the frame regardless of the verdict.
          for (int i = HIST_DEPTH - 1; i > 0; i--) begin
            hist[i]     <= hist[i-1];
            hist_vld[i] <= hist_vld[i-1];
          end
          hist[0]     <= cur_vec;
          hist_vld[0] <= 1'b1;
`ifdef DEDUP_DROP_CNT_EN
          if (!next_raw && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
`endif
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
